wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port (5-bit address, 32-bit data) between the
//  pipeline WB stage and the multi-cycle mult/div unit (MDU). Buffers MDU results in a
//  small FIFO and drains it into idle WB slots. Drives the write-address/data select.
//  Requests a pipeline freeze when a buffered result starves, and flags RAW hazards
//  against pending MDU destinations for the hazard unit.
// PARAMETERS
//  DEPTH        2   MDU result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT 4   cycles the FIFO head may wait before a forced drain
// PORTS
//  Clk         in   1   clock; all state updates on rising edge
//  Rst_n       in   1   asynchronous reset, active-low
//  pipe_we     in   1   WB stage requests a register write
//  pipe_rd     in   5   WB destination register
//  pipe_data   in   32  WB write data
//  mdu_valid   in   1   MDU result available this cycle
//  mdu_rd      in   5   MDU destination register
//  mdu_data    in   32  MDU result
//  mdu_ready   out  1   FIFO can accept; push only when mdu_valid && mdu_ready
//  id_rs       in   5   ID-stage source register A
//  id_rt       in   5   ID-stage source register B
//  raw_hazard  out  1   id_rs/id_rt (nonzero) matches a valid FIFO entry's rd
//  rf_we       out  1   register-file write enable
//  rf_waddr    out  5   register-file write address
//  rf_wdata    out  32  register-file write data
//  rf_sel      out  1   1 = pipeline source, 0 = MDU source (2:1 mux select)
//  stall_req   out  1   freeze pipeline; WB must hold pipe_we/pipe_rd/pipe_data stable
// BEHAVIOUR
//  Reset (Rst_n=0): FIFO empty, ptrs/count 0, age=0, state IDLE; rf_we=0, rf_sel=1,
//   rf_waddr=0, rf_wdata=0, stall_req=0, mdu_ready=0, raw_hazard=0. mdu_ready=1 from the
//   first edge after release. Reset mid-drain discards every buffered entry.
//  FIFO: push on edge when mdu_valid && mdu_ready; mdu_ready = !full (registered count,
//   no push-while-full even if a pop occurs that cycle). Push+pop same cycle legal when
//   not full; count unchanged. Pointers wrap modulo DEPTH. No bypass: an MDU result is
//   written no earlier than the cycle after its push (min latency 1).
//  States:
//   IDLE     FIFO empty. Grant pipeline: rf_sel=1, rf_we=pipe_we&&(pipe_rd!=0).
//            -> PIPE_PRI on push.
//   PIPE_PRI FIFO non-empty. If pipe_we: grant pipeline, age++ (saturating).
//            Else: grant head (rf_sel=0), pop, age<=0.
//            -> DRAIN when age reaches STARVE_LIMIT; -> IDLE when last entry pops, no push.
//   DRAIN    stall_req=1; grant head regardless of pipe_we, pop, age<=0.
//            -> IDLE if FIFO becomes empty, else -> PIPE_PRI (one entry per DRAIN visit).
//  Grant outputs are combinational from registered state/FIFO head and live inputs.
//  Register $0: a write with rd==0 is granted and consumes the slot (pops if MDU) but
//   rf_we=0. raw_hazard ignores rs/rt==0.
//  rf_waddr/rf_wdata follow the granted source; when rf_we=0 they still show it.
//  age counts only cycles where the head was present and not granted; it is reset on
//   every pop and held at 0 when FIFO empty.
//  Pipeline write is never dropped: in DRAIN the held pipe_* write is granted the
//   following cycle (PIPE_PRI/IDLE, pipe priority).
// STRUCTURE
//  Shared package wb_arb_pkg: state encoding (IDLE=2'd0, PIPE_PRI=2'd1, DRAIN=2'd2),
//   REG_ZERO=5'd0, SEL_PIPE=1'b1 / SEL_MDU=1'b0.
//  Sub-module mdu_result_fifo (DEPTH x {rd[4:0],data[31:0]}, count, head, per-entry
//   valid/rd exposed for the hazard compare). Arbiter FSM, age counter, hazard compare
//   in top.
// TESTING
//  1 Reset release, pipe_we=1 rd=8 data=0x1234 -> rf_we=1 waddr=8 wdata=0x1234 sel=1.
//  2 MDU push rd=5 data=0xCAFE, pipe_we=0 next cycle -> that cycle rf_sel=0 waddr=5,
//    FIFO empty after edge, state IDLE.
//  3 Two pushes, pipe_we=1 continuously -> stall_req=1 in the cycle age reaches 4,
//    head written with sel=0; pipe write (held) granted the cycle after; 2nd entry
//    drains via a second DRAIN visit.
//  4 Fill FIFO (2 entries) -> mdu_ready=0; mdu_valid held -> no push until count<2.
//  5 FIFO holds rd=12; id_rs=12 -> raw_hazard=1; id_rt=0 with entry rd=0 -> 0;
//    MDU rd=0 pop -> rf_we=0, entry consumed.
//  6 Assert Rst_n=0 while in DRAIN with 2 entries -> outputs reset values
//    asynchronously, no write of buffered data after release.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and constants for the WB write-port arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PIPE_PRI = 2'd1,
    DRAIN    = 2'd2
  } arb_state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic       SEL_PIPE = 1'b1;
  localparam logic       SEL_MDU  = 1'b0;
endpackage

// File: rtl/mdu_result_fifo.sv
// mdu_result_fifo: DEPTH-entry {rd,data} FIFO for MDU results, with per-entry
// valid/rd exposed so the top can compare pending destinations against ID sources.
module mdu_result_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [4:0]                   rd_i,
  input  logic [31:0]                  data_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [4:0]                   head_rd_o,
  output logic [31:0]                  head_data_o,
  output logic [DEPTH-1:0]             vld_o,
  output logic [4:0]                   ent_rd_o [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic [DEPTH-1:0] vld_q;
  logic [4:0]     rd_mem   [DEPTH];
  logic [31:0]    data_mem [DEPTH];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (push_i) begin
        wr_q        <= wr_q + 1'b1;
        vld_q[wr_q] <= 1'b1;
      end
      if (pop_i) begin
        rd_q        <= rd_q + 1'b1;
        vld_q[rd_q] <= 1'b0;
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  // Payload storage needs no reset: the valid bits and count gate every use.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      rd_mem[wr_q]   <= rd_i;
      data_mem[wr_q] <= data_i;
    end
  end
  assign count_o     = cnt_q;
  assign head_rd_o   = rd_mem[rd_q];
  assign head_data_o = data_mem[rd_q];
  assign vld_o       = vld_q;
  assign ent_rd_o    = rd_mem;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB stage and
// buffered MDU results; forces a drain (with pipeline freeze) when the head starves.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        raw_hazard,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_sel,
  output logic        stall_req
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(STARVE_LIMIT+1);
  arb_state_e       state_q, state_d;
  logic [AW-1:0]    age_q, age_d;
  logic             live_q;
  logic [CW-1:0]    count, count_nxt;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic [DEPTH-1:0] ent_vld;
  logic [4:0]       ent_rd [DEPTH];
  logic             push, grant_mdu;
  mdu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (Clk),
    .rst_ni      (Rst_n),
    .push_i      (push),
    .pop_i       (grant_mdu),
    .rd_i        (mdu_rd),
    .data_i      (mdu_data),
    .count_o     (count),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .vld_o       (ent_vld),
    .ent_rd_o    (ent_rd)
  );
  // live_q keeps mdu_ready low until the first edge after reset release.
  assign mdu_ready = live_q && (count != CW'(DEPTH));
  assign push      = mdu_valid && mdu_ready;
  always_comb begin
    state_d   = state_q;
    age_d     = age_q;
    grant_mdu = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      IDLE: begin
        age_d = '0;
      end
      PIPE_PRI: begin
        grant_mdu = !pipe_we;
        age_d     = pipe_we ? ((age_q == AW'(STARVE_LIMIT)) ? age_q : age_q + 1'b1) : '0;
      end
      DRAIN: begin
        stall_req = 1'b1;
        grant_mdu = 1'b1;
        age_d     = '0;
      end
      default: state_d = IDLE;
    endcase
    count_nxt = count + CW'(push) - CW'(grant_mdu);
    case (state_q)
      IDLE:     state_d = push ? PIPE_PRI : IDLE;
      PIPE_PRI: state_d = (age_d == AW'(STARVE_LIMIT)) ? DRAIN : ((count_nxt == '0) ? IDLE : PIPE_PRI);
      DRAIN:    state_d = (count_nxt == '0) ? IDLE : PIPE_PRI;
      default:  state_d = IDLE;
    endcase
    rf_sel   = grant_mdu ? SEL_MDU : SEL_PIPE;
    rf_we    = Rst_n && (grant_mdu ? (head_rd != REG_ZERO) : (pipe_we && pipe_rd != REG_ZERO));
    rf_waddr = !Rst_n ? '0 : grant_mdu ? head_rd : pipe_rd;
    rf_wdata = !Rst_n ? '0 : grant_mdu ? head_data : pipe_data;
  end
  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      raw_hazard |= ent_vld[i] && ((id_rs != REG_ZERO && ent_rd[i] == id_rs) ||
                                   (id_rt != REG_ZERO && ent_rd[i] == id_rt));
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      age_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      live_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus with a write scoreboard; the monitor pops an
// expected {addr,data,sel,stall} every cycle the DUT asserts rf_we.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        Rst_n;
  logic        pipe_we, mdu_valid, mdu_ready, raw_hazard, rf_we, rf_sel, stall_req;
  logic [4:0]  pipe_rd, mdu_rd, id_rs, id_rt, rf_waddr;
  logic [31:0] pipe_data, mdu_data, rf_wdata;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        sel;
    logic        stall;
  } wr_t;
  wr_t exp_q[$];
  always #5 clk = ~clk;
  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .Clk(clk), .Rst_n(Rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .id_rs(id_rs), .id_rt(id_rt), .raw_hazard(raw_hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_sel(rf_sel),
    .stall_req(stall_req)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic ew(input logic [4:0] a, input logic [31:0] d, input logic s, input logic st);
    wr_t e;
    e.a = a; e.d = d; e.sel = s; e.stall = st;
    exp_q.push_back(e);
  endtask
  task automatic cyc(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    @(posedge clk);
    #1;
    pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rf_we"}, 32'(rf_we), 0);
    chk({tag, "_rf_sel"}, 32'(rf_sel), 1);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_stall"}, 32'(stall_req), 0);
    chk({tag, "_mdu_ready"}, 32'(mdu_ready), 0);
    chk({tag, "_raw"}, 32'(raw_hazard), 0);
  endtask
  always @(negedge clk) begin
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h sel=%0b expected no write", rf_waddr, rf_wdata, rf_sel);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rf_waddr), 32'(e.a));
        chk("wr_data", rf_wdata, e.d);
        chk("wr_sel", 32'(rf_sel), 32'(e.sel));
        chk("wr_stall", 32'(stall_req), 32'(e.stall));
      end
    end
  end
  initial begin
    Rst_n = 1'b0;
    pipe_we = 1'b1; pipe_rd = 5'd8; pipe_data = 32'h1234;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    id_rs = '0; id_rt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    // reset release: pipeline write granted immediately, mdu_ready waits for an edge
    ew(5'd8, 32'h1234, 1'b1, 1'b0);
    Rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(mdu_ready), 0);
    cyc(0, 0, 0, 1, 5'd5, 32'hCAFE);
    #2;
    chk("ready_after_edge", 32'(mdu_ready), 1);
    chk("no_bypass_we", 32'(rf_we), 0);
    cyc(0, 0, 0, 0, 0, 0);
    id_rs = 5'd5;
    ew(5'd5, 32'hCAFE, 1'b0, 1'b0);
    #2;
    chk("mdu_grant_sel", 32'(rf_sel), 0);
    chk("raw_pending5", 32'(raw_hazard), 1);
    cyc(1, 5'd3, 32'h7, 0, 0, 0);
    ew(5'd3, 32'h7, 1'b1, 1'b0);
    #2;
    chk("raw_after_pop", 32'(raw_hazard), 0);
    chk("idle_sel", 32'(rf_sel), 1);
    id_rs = '0;
    // starvation: two buffered entries, pipeline writing every cycle
    cyc(1, 5'd9, 32'h900, 1, 5'd10, 32'hA0); ew(5'd9, 32'h900, 1'b1, 1'b0);
    cyc(1, 5'd9, 32'h901, 1, 5'd11, 32'hB0); ew(5'd9, 32'h901, 1'b1, 1'b0);
    cyc(1, 5'd9, 32'h902, 0, 0, 0);          ew(5'd9, 32'h902, 1'b1, 1'b0);
    #2;
    chk("full_ready", 32'(mdu_ready), 0);
    chk("no_stall_yet", 32'(stall_req), 0);
    cyc(1, 5'd9, 32'h903, 0, 0, 0);          ew(5'd9, 32'h903, 1'b1, 1'b0);
    cyc(1, 5'd9, 32'h904, 0, 0, 0);          ew(5'd9, 32'h904, 1'b1, 1'b0);
    cyc(1, 5'd9, 32'h905, 0, 0, 0);          ew(5'd10, 32'hA0, 1'b0, 1'b1);
    #2;
    chk("drain1_stall", 32'(stall_req), 1);
    cyc(1, 5'd9, 32'h905, 0, 0, 0);          ew(5'd9, 32'h905, 1'b1, 1'b0);
    #2;
    chk("post_drain_stall", 32'(stall_req), 0);
    for (int k = 6; k <= 8; k++) begin
      cyc(1, 5'd9, 32'h900 + 32'(k), 0, 0, 0);
      ew(5'd9, 32'h900 + 32'(k), 1'b1, 1'b0);
    end
    cyc(1, 5'd9, 32'h909, 0, 0, 0);          ew(5'd11, 32'hB0, 1'b0, 1'b1);
    cyc(1, 5'd9, 32'h909, 0, 0, 0);          ew(5'd9, 32'h909, 1'b1, 1'b0);
    // full FIFO back-pressure with mdu_valid held
    cyc(1, 5'd20, 32'h20, 1, 5'd13, 32'hD0); ew(5'd20, 32'h20, 1'b1, 1'b0);
    cyc(1, 5'd21, 32'h21, 1, 5'd14, 32'hE0); ew(5'd21, 32'h21, 1'b1, 1'b0);
    cyc(1, 5'd22, 32'h22, 1, 5'd15, 32'hF0); ew(5'd22, 32'h22, 1'b1, 1'b0);
    #2;
    chk("bp_ready_full", 32'(mdu_ready), 0);
    cyc(0, 0, 0, 1, 5'd15, 32'hF0);          ew(5'd13, 32'hD0, 1'b0, 1'b0);
    #2;
    chk("bp_ready_pop_cycle", 32'(mdu_ready), 0);
    cyc(0, 0, 0, 1, 5'd15, 32'hF0);          ew(5'd14, 32'hE0, 1'b0, 1'b0);
    #2;
    chk("bp_ready_reopen", 32'(mdu_ready), 1);
    cyc(0, 0, 0, 0, 0, 0);                   ew(5'd15, 32'hF0, 1'b0, 1'b0);
    // register $0 handling and hazard compare
    cyc(1, 5'd0, 32'h55, 1, 5'd12, 32'hC0);
    #2;
    chk("pipe_r0_we", 32'(rf_we), 0);
    chk("pipe_r0_sel", 32'(rf_sel), 1);
    cyc(1, 5'd0, 32'h55, 1, 5'd0, 32'h77);
    id_rs = 5'd12;
    #2;
    chk("raw_rs12", 32'(raw_hazard), 1);
    cyc(0, 0, 0, 0, 0, 0);
    id_rs = '0; id_rt = '0;
    ew(5'd12, 32'hC0, 1'b0, 1'b0);
    #2;
    chk("raw_zero_ignored", 32'(raw_hazard), 0);
    cyc(0, 0, 0, 0, 0, 0);
    #2;
    chk("mdu_r0_we", 32'(rf_we), 0);
    chk("mdu_r0_sel", 32'(rf_sel), 0);
    chk("mdu_r0_waddr", 32'(rf_waddr), 0);
    chk("mdu_r0_wdata", rf_wdata, 32'h77);
    cyc(0, 0, 0, 0, 0, 0);
    #2;
    chk("r0_consumed_sel", 32'(rf_sel), 1);
    // reset while draining with two entries buffered
    cyc(1, 5'd30, 32'h30, 1, 5'd16, 32'h16); ew(5'd30, 32'h30, 1'b1, 1'b0);
    cyc(1, 5'd31, 32'h31, 1, 5'd17, 32'h17); ew(5'd31, 32'h31, 1'b1, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      cyc(1, 5'd30, 32'h30 + 32'(k), 0, 0, 0);
      ew(5'd30, 32'h30 + 32'(k), 1'b1, 1'b0);
    end
    cyc(1, 5'd30, 32'h35, 0, 0, 0);
    id_rs = 5'd17;
    #1;
    chk("pre_reset_stall", 32'(stall_req), 1);
    chk("pre_reset_raw", 32'(raw_hazard), 1);
    #1;
    Rst_n = 1'b0;
    #1;
    chk_reset("mid_drain_rst");
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    pipe_we = 1'b0;
    repeat (6) cyc(0, 0, 0, 0, 0, 0);
    #2;
    chk("post_rst_raw", 32'(raw_hazard), 0);
    chk("post_rst_sel", 32'(rf_sel), 1);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
